// File: rtl/multiword_adder_seq_if.sv
// Bundle for the multiword add/subtract sequencer: request/result handshake
// toward ALU-control decode plus the word-wide port to the shared 16-bit adder.
interface multiword_adder_seq_if #(
  parameter int WORDS = 2
);
  localparam int W = 16 * WORDS;

  logic         START;
  logic [1:0]   OP;
  logic         CIN;
  logic [W-1:0] OPA;
  logic [W-1:0] OPB;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] RESULT;
  logic         COUT;
  logic         FLAG_V;
  logic         FLAG_Z;
  logic         FLAG_N;
  logic [15:0]  ADD_A;
  logic [15:0]  ADD_B;
  logic         ADD_SUB;
  logic         ADD_SBB;
  logic         ADD_ADC;
  logic         ADD_C;
  logic [15:0]  ADD_Y;
  logic         ADD_COUT;
  logic         ADD_COUT_1;

  // The sequencer itself.
  modport slave (
    input  START, OP, CIN, OPA, OPB, ADD_Y, ADD_COUT, ADD_COUT_1,
    output BUSY, DONE, RESULT, COUT, FLAG_V, FLAG_Z, FLAG_N,
           ADD_A, ADD_B, ADD_SUB, ADD_SBB, ADD_ADC, ADD_C
  );

  // The environment: requester plus the adder datapath.
  modport master (
    output START, OP, CIN, OPA, OPB, ADD_Y, ADD_COUT, ADD_COUT_1,
    input  BUSY, DONE, RESULT, COUT, FLAG_V, FLAG_Z, FLAG_N,
           ADD_A, ADD_B, ADD_SUB, ADD_SBB, ADD_ADC, ADD_C
  );
endinterface

// File: rtl/multiword_adder_seq.sv
// Sequences a WORDS x 16-bit add/subtract through the shared 16-bit adder, LSW first.
// Optional macro OVF_EN builds the V/Z/N flag registers; otherwise the flags are tied low.
module multiword_adder_seq #(
  parameter int WORDS = 2
) (
  input logic                 CLK,
  input logic                 RST,
  multiword_adder_seq_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  result_q;
  logic [1:0]    op_q;
  logic          cin_q;
  logic          carry_q;
  logic          cout_q;
  logic          run;
  logic          is_sub;
  logic          with_c;
  logic          accept;

  assign run    = (state == S_RUN);
  assign is_sub = op_q[1];
  assign with_c = op_q[0];
  assign accept = (state == S_IDLE) && bus.START;

  // Word k is presented to the combinational adder throughout RUN.
  always_comb begin
    bus.ADD_A   = '0;
    bus.ADD_B   = '0;
    bus.ADD_SUB = 1'b0;
    bus.ADD_SBB = 1'b0;
    bus.ADD_ADC = 1'b0;
    bus.ADD_C   = 1'b0;
    if (run) begin
      bus.ADD_A = a_q[{k, 4'b0000} +: 16];
      bus.ADD_B = b_q[{k, 4'b0000} +: 16];
      if (k == '0) begin
        bus.ADD_SUB = is_sub & ~with_c;
        bus.ADD_SBB = is_sub & with_c;
        bus.ADD_ADC = ~is_sub & with_c;
        bus.ADD_C   = with_c & cin_q;
      end else begin
        // The adder reports no-borrow on subtract, so the chained borrow is its inverse.
        bus.ADD_SBB = is_sub;
        bus.ADD_ADC = ~is_sub;
        bus.ADD_C   = is_sub ? ~carry_q : carry_q;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      a_q <= bus.OPA;
      b_q <= bus.OPB;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      k        <= '0;
      result_q <= '0;
      op_q     <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            op_q  <= bus.OP;
            cin_q <= bus.CIN;
            k     <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          result_q[{k, 4'b0000} +: 16] <= bus.ADD_Y;
          carry_q <= bus.ADD_COUT;
          if (k == K_LAST) begin
            cout_q <= bus.ADD_COUT;
            k      <= '0;
            state  <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY   = run;
  assign bus.DONE   = (state == S_DONE);
  assign bus.RESULT = result_q;
  assign bus.COUT   = cout_q;

`ifdef OVF_EN
  logic [W-1:0] result_nxt;
  logic         flag_v_q;
  logic         flag_z_q;
  logic         flag_n_q;

  // Flags are taken from the final result as it is being written on the MSW edge.
  always_comb begin
    result_nxt = result_q;
    result_nxt[{k, 4'b0000} +: 16] = bus.ADD_Y;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (run && (k == K_LAST)) begin
      flag_v_q <= bus.ADD_COUT ^ bus.ADD_COUT_1;
      flag_z_q <= (result_nxt == '0);
      flag_n_q <= bus.ADD_Y[15];
    end
  end

  assign bus.FLAG_V = flag_v_q;
  assign bus.FLAG_Z = flag_z_q;
  assign bus.FLAG_N = flag_n_q;
`else
  assign bus.FLAG_V = 1'b0;
  assign bus.FLAG_Z = 1'b0;
  assign bus.FLAG_N = 1'b0;
`endif
endmodule

// File: doc/multiword_adder_seq.md
Name: multiword_adder_seq

Overview:
- Sequencer that performs WORDS×16-bit add/subtract by driving the shared 16-bit two's-complement adder (ops ADD/ADC/SUB/SBB) one word per cycle, LSW first.
- Carries/borrows are chained between words through the adder's C input.
- Sits between the ALU-control decode and the 16-bit adder datapath. Provides a start/busy/done handshake and a registered full-width result with final carry.

Parameters:
WORDS, 2, number of 16-bit words per operand (legal 1..8); operand width W = 16*WORDS.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request; accepted only in IDLE
OP  input  2  00 ADD, 01 ADC, 10 SUB, 11 SBB; sampled with START
CIN  input  1  initial carry (ADC) or initial borrow (SBB); ignored for ADD/SUB; sampled with START
OPA  input  W  operand A; sampled with START
OPB  input  W  operand B; sampled with START
BUSY  output  1  high in RUN
DONE  output  1  one-cycle pulse when RESULT is valid
RESULT  output  W  registered sum/difference; held until next accepted START
COUT  output  1  final carry (add) / no-borrow (sub, 1 = no borrow)
FLAG_V  output  1  signed overflow (OVF_EN)
FLAG_Z  output  1  RESULT == 0 (OVF_EN)
FLAG_N  output  1  RESULT[W-1] (OVF_EN)
ADD_A  output  16  adder operand A word
ADD_B  output  16  adder operand B word
ADD_SUB  output  1  adder SUB control
ADD_SBB  output  1  adder SBB control
ADD_ADC  output  1  adder ADC control
ADD_C  output  1  adder carry/borrow input
ADD_Y  input  16  adder result
ADD_COUT  input  1  adder carry out of bit 15
ADD_COUT_1  input  1  adder carry into bit 15

Behaviour:
- Adder contract:
  - ADD: Y=A+B.
  - ADC: Y=A+B+C.
  - SUB: Y=A-B.
  - SBB: Y=A-B-C, with C=1 meaning borrow.
  - For SUB/SBB, COUT=1 means no borrow.
  - At most one of ADD_SUB/ADD_SBB/ADD_ADC is high; all low selects ADD.
- Reset (any state, including mid-operation): state=IDLE, word index k=0, BUSY=0, DONE=0, RESULT=0, COUT=0, flags=0, all ADD_* outputs 0. Any operation in progress is discarded.
- States: IDLE, RUN, DONE_S.
  - IDLE: on START=1, latch OPA/OPB/OP/CIN, set k=0, go to RUN. START=0 stays in IDLE.
  - RUN: the adder is combinational.
    - ADD_A = A word k, ADD_B = B word k.
    - Control for k=0:
      - ADD → all controls 0.
      - SUB → ADD_SUB=1.
      - ADC → ADD_ADC=1, ADD_C=CIN.
      - SBB → ADD_SBB=1, ADD_C=CIN.
    - Control for k>0:
      - add ops → ADD_ADC=1, ADD_C=carry register.
      - sub ops → ADD_SBB=1, ADD_C=~carry register.
    - At each edge: RESULT word k ← ADD_Y; carry register ← ADD_COUT; k ← k+1.
    - After word WORDS-1, go to DONE_S.
  - DONE_S: DONE=1 for exactly one cycle, COUT=carry register, then go to IDLE.
- Latency: START accepted at edge 0; DONE high in cycle WORDS+1; a new START is accepted the cycle after DONE.
- BUSY=1 only in RUN.
- START outside IDLE is ignored; no queueing.
- In IDLE and DONE_S, ADD_* outputs are 0.
- RESULT words are overwritten progressively during RUN. RESULT is valid only while DONE=1 and afterwards until the next START.
- WORDS=1 degenerates to a single adder cycle (DONE at cycle 2).
- k is wide enough for WORDS=8 and never wraps past WORDS-1.

Optional Feature:
- Macro OVF_EN.
- Defined:
  - The MSW cycle captures V = ADD_COUT ^ ADD_COUT_1.
  - FLAG_Z and FLAG_N are computed from the final RESULT.
  - All three flags update together with DONE and hold until the next DONE; reset clears them.
- Undefined: FLAG_V/FLAG_Z/FLAG_N are tied to 0 and no flag logic is built.

Test Plan (WORDS=2):
- Reset mid-RUN: START ADD, assert RST in the first RUN cycle → next cycle IDLE, BUSY=0, RESULT=0, no DONE pulse.
- ADD 0x00014567 + 0x0000FFFF → DONE in cycle 3, RESULT=0x00024566, COUT=0, BUSY high for 2 cycles. Second word observed as ADD_ADC=1, ADD_C=1.
- SUB 0x00010000 - 0x00000001 → RESULT=0x0000FFFF, COUT=1. Second word observed as ADD_SBB=1, ADD_C=1 (borrow).
- SBB CIN=1: 0x45671234 - 0x12341234 → RESULT=0x3332FFFF, COUT=1.
- ADC CIN=1: 0xFFFFFFFF + 0x00000000 → RESULT=0x00000000, COUT=1; with OVF_EN: Z=1, V=0, N=0.
- OVF_EN: ADD 0x7FFFFFFF + 0x00000001 → RESULT=0x80000000, V=1, N=1, Z=0, COUT=0. A START pulse during BUSY is ignored and produces exactly one DONE.
